sized_data_memory: RTL

Parametrised data memory for the MIPS datapath: byte-addressed loads and stores of byte, halfword, word or (64-bit builds) doubleword, with sign/zero extension, per-byte write lanes, misalignment and range checking, and a configurable wait-state count behind a valid/ready request and response handshake. It sits between the load/store stage and the word-array RAM and allows the pipeline to tolerate slow memory.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/data_memory_align.sv | 47 ++++
 rtl/sized_data_memory.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-enable vector for an access of the given size starting at lane.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      SIZE_HALF:   return lane[0];
      SIZE_WORD:   return lane[1:0] != 2'b00;
      SIZE_DOUBLE: return lane != 3'b000;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_align.sv
// Load lane extraction with sign/zero extension, and store-data lane replication.
module data_memory_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]                      size_i,
  input  logic                            unsigned_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] lane_i,
  input  logic [DATA_WIDTH-1:0]           rd_word_i,
  input  logic [DATA_WIDTH-1:0]           st_data_i,
  output logic [DATA_WIDTH-1:0]           ld_data_c_o,
  output logic [DATA_WIDTH-1:0]           st_word_c_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic                  sign_bit;

  // A full-width mask leaves no bits to extend, so full-width loads ignore unsigned_i.
  always_comb begin
    shifted     = rd_word_i >> {lane_i, 3'b000};
    keep_mask   = '1;
    sign_bit    = shifted[DATA_WIDTH-1];
    st_word_c_o = st_data_i;
    case (size_i)
      SIZE_BYTE: begin
        keep_mask   = DATA_WIDTH'(8'hFF);
        sign_bit    = shifted[7];
        st_word_c_o = {(DATA_WIDTH/8){st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        keep_mask   = DATA_WIDTH'(16'hFFFF);
        sign_bit    = shifted[15];
        st_word_c_o = {(DATA_WIDTH/16){st_data_i[15:0]}};
      end
      SIZE_WORD: begin
        keep_mask   = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit    = shifted[31];
        st_word_c_o = {(DATA_WIDTH/32){st_data_i[31:0]}};
      end
      default: ;
    endcase
    ld_data_c_o = (shifted & keep_mask) | ((sign_bit && !unsigned_i) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed sized load/store memory with wait states behind valid/ready handshakes.
module sized_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OB     = $clog2(NBYTES);
  localparam int unsigned IB     = $clog2(MEMORY_DEPTH);
  localparam int unsigned CW     = 4;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  write_q, uns_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;

  logic [NBYTES-1:0][7:0] mem_q [MEMORY_DEPTH];

  logic                  latch_c, access_c, err_c, wr_en_c;
  logic [IB-1:0]         idx_c;
  logic [OB-1:0]         lane_c;
  logic [NBYTES-1:0]     be_c;
  logic [DATA_WIDTH-1:0] rd_word_c, ld_c, st_c;

  assign idx_c     = addr_q[OB +: IB];
  assign lane_c    = addr_q[OB-1:0];
  assign be_c      = NBYTES'(lane_mask(size_q, 3'(lane_c)));
  assign rd_word_c = mem_q[idx_c];
  assign err_c     = misaligned(size_q, 3'(lane_c))
                   | ((DATA_WIDTH == 32) && (size_q == SIZE_DOUBLE))
                   | ((addr_q >> (OB + IB)) != '0);
  assign wr_en_c   = access_c & write_q & ~err_c;

  data_memory_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .lane_i      (lane_c),
    .rd_word_i   (rd_word_c),
    .st_data_i   (wdata_q),
    .ld_data_c_o (ld_c),
    .st_word_c_o (st_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_c      = 1'b0;
    access_c     = 1'b0;
    out_data_d   = out_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          latch_c = 1'b1;
          cnt_d   = CW'(WAIT_STATES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          access_c     = 1'b1;
          state_d      = ST_RESP;
          resp_error_d = err_c;
          out_data_d   = (err_c || write_q) ? '0 : ld_c;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_error_d = 1'b0;
          out_data_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      out_data_q   <= out_data_d;
    end
  end

  // Request fields are captured only at the acceptance edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_c) begin
      write_q <= req_write;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= address;
      wdata_q <= in_data;
    end
  end

  // RAM contents survive reset; only the enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_c[b]) mem_q[idx_c][b] <= st_c[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign out_data   = out_data_q;

endmodule
